// File: rtl/pll_clken_pkg.sv
// Shared types and default sizing for the PLL-lock-qualified clock-enable generator.
package pll_clken_pkg;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_LOCK_FILT = 64;

    typedef enum logic [1:0] {
        ST_FILTER = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOST   = 2'd2
    } pll_state_t;

endpackage

// File: rtl/pll_clken_ch.sv
// One output channel: shadow divide/phase with clamping, phase counter and registered enable/divided-clock decode.
module pll_clken_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             run,
    input  logic             run_nxt,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] phase,
    output logic             clk_en,
    output logic             clk_div
);

    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] p_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] n_in_s;
    logic [CNT_W-1:0] p_in_s;
    logic [CNT_W-1:0] n_nxt_s;
    logic [CNT_W-1:0] p_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W:0]   half_s;

    // Clamp incoming config and compute next counter; outputs are decoded one cycle ahead.
    always_comb begin
        n_in_s = (div == '0) ? CNT_W'(1) : div;
        p_in_s = (phase >= n_in_s) ? (n_in_s - CNT_W'(1)) : phase;
        if (load) begin
            n_nxt_s = n_in_s;
            p_nxt_s = p_in_s;
        end else begin
            n_nxt_s = n_r;
            p_nxt_s = p_r;
        end
        // A reload or RUN entry restarts the sequence at the (new) phase offset.
        if (run && !load) begin
            cnt_nxt_s = (cnt_r == (n_r - CNT_W'(1))) ? '0 : (cnt_r + CNT_W'(1));
        end else begin
            cnt_nxt_s = p_nxt_s;
        end
        half_s = ({1'b0, n_nxt_s} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    end

    // Shadow, counter and output registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            n_r     <= CNT_W'(1);
            p_r     <= '0;
            cnt_r   <= '0;
            clk_en  <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            n_r     <= n_nxt_s;
            p_r     <= p_nxt_s;
            cnt_r   <= cnt_nxt_s;
            clk_en  <= run_nxt & en & (cnt_nxt_s == (n_nxt_s - CNT_W'(1)));
            clk_div <= run_nxt & en & ({1'b0, cnt_nxt_s} < half_s);
        end
    end

endmodule

// File: rtl/pll_clken_gen.sv
// Lock-filtered clock-enable generator: qualifies raw PLL lock, then runs NUM_CH phase-programmable dividers.
module pll_clken_gen
    import pll_clken_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LOCK_FILT = DEF_LOCK_FILT
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic                    pll_lock,
    input  logic [NUM_CH*CNT_W-1:0] div_sel,
    input  logic [NUM_CH*CNT_W-1:0] phase_sel,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    lock_lost_clr,
    output logic [NUM_CH-1:0]       clk_en,
    output logic [NUM_CH-1:0]       clk_div,
    output logic                    ready,
    output logic                    lock_lost
);

    localparam int FW = $clog2(LOCK_FILT + 1);

    logic          lock_meta_r;
    logic          lock_s_r;
    pll_state_t    state_r;
    pll_state_t    state_nxt_s;
    logic [FW-1:0] filt_r;
    logic [FW-1:0] filt_nxt_s;
    logic          run_s;
    logic          run_nxt_s;

    // Next-state and lock filter counter.
    always_comb begin
        state_nxt_s = state_r;
        filt_nxt_s  = filt_r;
        case (state_r)
            ST_FILTER: begin
                if (filt_r == FW'(LOCK_FILT)) begin
                    state_nxt_s = ST_RUN;
                    filt_nxt_s  = '0;
                end else if (lock_s_r) begin
                    filt_nxt_s  = filt_r + FW'(1);
                end else begin
                    filt_nxt_s  = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s_r) begin
                    state_nxt_s = ST_LOST;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOST: begin
                state_nxt_s = ST_FILTER;
                filt_nxt_s  = '0;
            end
            default: begin
                state_nxt_s = ST_FILTER;
                filt_nxt_s  = '0;
            end
        endcase
    end

    assign run_s     = (state_r == ST_RUN);
    assign run_nxt_s = (state_nxt_s == ST_RUN);

    // Lock synchroniser, FSM state, ready and sticky lock-lost flag.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
            state_r     <= ST_FILTER;
            filt_r      <= '0;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_s_r    <= lock_meta_r;
            state_r     <= state_nxt_s;
            filt_r      <= filt_nxt_s;
            ready       <= run_nxt_s;
            if (run_s && (state_nxt_s == ST_LOST)) begin
                lock_lost <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end else begin
                lock_lost <= lock_lost;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_clken_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clkin   (clkin),
            .reset   (reset),
            .run     (run_s),
            .run_nxt (run_nxt_s),
            .load    (cfg_load),
            .en      (ch_en[i]),
            .div     (div_sel[i*CNT_W +: CNT_W]),
            .phase   (phase_sel[i*CNT_W +: CNT_W]),
            .clk_en  (clk_en[i]),
            .clk_div (clk_div[i])
        );
    end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen; expected output vectors are queued with each stimulus step and checked after the edge.
module tb_pll_clken_gen;

    localparam int NUM_CH    = 3;
    localparam int CNT_W     = 8;
    localparam int LOCK_FILT = 16;

    logic        clkin = 1'b0;
    logic        reset;
    logic        pll_lock;
    logic [23:0] div_sel;
    logic [23:0] phase_sel;
    logic        cfg_load;
    logic [2:0]  ch_en;
    logic        lock_lost_clr;
    logic [2:0]  clk_en;
    logic [2:0]  clk_div;
    logic        ready;
    logic        lock_lost;

    int          checks   = 0;
    int          failures = 0;
    int          n_m[3];
    int          p_m[3];
    string       tag_q[$];
    logic [7:0]  exp_q[$];

    always #5 clkin = ~clkin;

    pll_clken_gen #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .LOCK_FILT (LOCK_FILT)
    ) dut (
        .clkin         (clkin),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .div_sel       (div_sel),
        .phase_sel     (phase_sel),
        .cfg_load      (cfg_load),
        .ch_en         (ch_en),
        .lock_lost_clr (lock_lost_clr),
        .clk_en        (clk_en),
        .clk_div       (clk_div),
        .ready         (ready),
        .lock_lost     (lock_lost)
    );

    // Expected {lock_lost, ready, clk_div[2:0], clk_en[2:0]} in RUN cycle t: cnt = (P + t) mod N.
    function automatic logic [7:0] run_vec(input int t, input logic ll);
        logic [2:0] e;
        logic [2:0] d;
        int         c;
        for (int i = 0; i < 3; i++) begin
            c    = (p_m[i] + t) % n_m[i];
            e[i] = ch_en[i] && (c == n_m[i] - 1);
            d[i] = ch_en[i] && (c < (n_m[i] + 1) / 2);
        end
        return {ll, 1'b1, d, e};
    endfunction

    task automatic expect_next(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic cyc();
        string      tg;
        logic [7:0] ex;
        logic [7:0] obs;
        @(posedge clkin);
        #1;
        while (exp_q.size() > 0) begin
            tg  = tag_q.pop_front();
            ex  = exp_q.pop_front();
            obs = {lock_lost, ready, clk_div, clk_en};
            checks++;
            assert (obs === ex) else begin
                failures++;
                $error("FAIL %s t=%0t observed=%b expected=%b", tg, $time, obs, ex);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        pll_lock      = 1'b0;
        cfg_load      = 1'b0;
        lock_lost_clr = 1'b0;
        ch_en         = 3'b111;
        div_sel       = 24'd0;
        phase_sel     = 24'd0;
        for (int k = 0; k < 3; k++) begin
            expect_next("reset_state", 8'h00);
            cyc();
        end

        // Lock high from the first cycle after reset; configure N={4,3,1}, P={0,2,0} while filtering.
        reset    = 1'b0;
        pll_lock = 1'b1;
        n_m      = '{4, 3, 1};
        p_m      = '{0, 2, 0};
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) begin
                cfg_load  = 1'b1;
                div_sel   = {8'd1, 8'd3, 8'd4};
                phase_sel = {8'd0, 8'd2, 8'd0};
            end else begin
                cfg_load  = 1'b0;
            end
            expect_next("lock_filter", 8'h00);
            cyc();
        end
        for (int t = 0; t < 12; t++) begin
            expect_next("run_pattern", run_vec(t, 1'b0));
            cyc();
        end

        // Channel 0 gated off for five cycles; phase must be unaffected.
        for (int t = 12; t <= 24; t++) begin
            ch_en[0] = !((t >= 14) && (t < 19));
            expect_next("ch_en_gate", run_vec(t, 1'b0));
            cyc();
        end
        ch_en = 3'b111;

        // Reload in RUN: ch0 N=0 -> 1, ch1 N=5 P=9 -> P=4.
        cfg_load  = 1'b1;
        div_sel   = {8'd1, 8'd5, 8'd0};
        phase_sel = {8'd0, 8'd9, 8'd9};
        n_m       = '{1, 5, 1};
        p_m       = '{0, 4, 0};
        expect_next("reload", run_vec(0, 1'b0));
        cyc();
        cfg_load = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            expect_next("reload", run_vec(t, 1'b0));
            cyc();
        end

        // Lock drop in RUN: two more RUN cycles, then LOST with clear and cfg_load coincident.
        pll_lock = 1'b0;
        expect_next("lost_wait", run_vec(11, 1'b0));
        cyc();
        expect_next("lost_wait", run_vec(12, 1'b0));
        cyc();
        lock_lost_clr = 1'b1;
        cfg_load      = 1'b1;
        div_sel       = {8'd2, 8'd6, 8'd2};
        phase_sel     = {8'd1, 8'd3, 8'd0};
        expect_next("lost_set", 8'h80);
        cyc();
        lock_lost_clr = 1'b0;
        cfg_load      = 1'b0;
        expect_next("lost_hold", 8'h80);
        cyc();
        lock_lost_clr = 1'b1;
        expect_next("lost_clr", 8'h00);
        cyc();
        lock_lost_clr = 1'b0;

        // Re-acquire with a one-cycle lock glitch at filter count 10; ready 11 cycles late.
        n_m = '{2, 6, 2};
        p_m = '{0, 3, 1};
        for (int k = 1; k <= 29; k++) begin
            pll_lock = (k != 11);
            expect_next("glitch_filter", 8'h00);
            cyc();
        end
        for (int t = 0; t < 8; t++) begin
            expect_next("relock_cfg", run_vec(t, 1'b0));
            cyc();
        end

        // Reset mid-RUN drops everything and restores default shadows N=1 P=0.
        reset = 1'b1;
        expect_next("reset_run", 8'h00);
        cyc();
        expect_next("reset_run", 8'h00);
        cyc();
        reset = 1'b0;
        n_m   = '{1, 1, 1};
        p_m   = '{0, 0, 0};
        for (int k = 1; k <= 18; k++) begin
            expect_next("reset_filter", 8'h00);
            cyc();
        end
        for (int t = 0; t < 4; t++) begin
            expect_next("default_cfg", run_vec(t, 1'b0));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_clken_gen.md
PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

Interface
REQ-001 Parameter NUM_CH, default 3, number of output channels (1..8).
REQ-002 Parameter CNT_W, default 8, width of per-channel divide and phase fields.
REQ-003 Parameter LOCK_FILT, default 64, consecutive synchronised lock-high cycles required before RUN (2..2^16).
REQ-004 clkin  input  1  sole clock; all logic rising-edge on clkin.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pll_lock  input  1  raw PLL lock, asynchronous to clkin.
REQ-007 div_sel  input  NUM_CH*CNT_W  divide ratio N per channel, channel i at bits [i*CNT_W +: CNT_W].
REQ-008 phase_sel  input  NUM_CH*CNT_W  start offset P per channel, same packing.
REQ-009 cfg_load  input  1  single-cycle pulse; captures div_sel/phase_sel into shadow registers.
REQ-010 ch_en  input  NUM_CH  per-channel output gate.
REQ-011 lock_lost_clr  input  1  clears sticky lock_lost.
REQ-012 clk_en  output  NUM_CH  one-cycle clock-enable pulse per channel.
REQ-013 clk_div  output  NUM_CH  divided square wave per channel.
REQ-014 ready  output  1  high when state is RUN.
REQ-015 lock_lost  output  1  sticky flag: lock dropped while in RUN.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchroniser (lock_s) before any use.
REQ-017 States: FILTER, RUN, LOST.
REQ-018 FILTER: counter increments on lock_s=1, clears to 0 on lock_s=0; on reaching LOCK_FILT -> RUN next cycle, counter cleared.
REQ-019 RUN: lock_s=0 -> LOST next cycle; otherwise stay.
REQ-020 LOST: lasts exactly one cycle, then FILTER with counter 0.
REQ-021 Shadow N of 0 SHALL be treated as 1; shadow P >= N SHALL be clamped to N-1.
REQ-022 Per-channel counter in RUN cycle t (t=0 first RUN cycle or first cycle after reload): cnt = (P + t) mod N.
REQ-023 clk_en[i] = RUN and ch_en[i] and cnt_i = N_i-1; clk_div[i] = RUN and ch_en[i] and cnt_i < (N_i+1)/2 (integer division).
REQ-024 clk_en, clk_div, ready SHALL be driven directly from flops (registered lookahead), no combinational path from inputs.
REQ-025 Outside RUN, clk_en, clk_div, ready SHALL be 0.
REQ-026 cfg_load in RUN: shadows update and all counters reload (t restarts at 0) in the following cycle; outputs keep the old configuration in the load cycle.
REQ-027 cfg_load outside RUN: shadows update only; counters start at P on RUN entry.
REQ-028 ch_en gates outputs only; counters run regardless of ch_en, so re-enabling preserves phase.
REQ-029 lock_lost set on RUN->LOST transition; cleared by lock_lost_clr; set wins if both occur in the same cycle.
REQ-030 cfg_load coincident with RUN->LOST: shadows update; no output pulses.

Reset
REQ-031 reset SHALL force state FILTER, filter counter 0, synchroniser flops 0, all shadows N=1 P=0, all counters 0, all outputs 0, lock_lost 0.
REQ-032 reset asserted mid-RUN SHALL drop outputs to 0 in the next cycle; reset has priority over every other input.

Structure
REQ-033 Package pll_clken_pkg SHALL hold the state enum and defaults for CNT_W and LOCK_FILT.
REQ-034 Per-channel counter, clamp and output decode SHALL live in sub-module pll_clken_ch, instantiated NUM_CH times by generate loop.

Verification (LOCK_FILT=16, NUM_CH=3, CNT_W=8)
REQ-035 pll_lock high from cycle 0 -> ready rises at cycle 2+16+1 = 19 (±0) after reset release; no clk_en before that.
REQ-036 N={4,3,1}, P={0,2,0}, all ch_en -> ch0 clk_en at t=3,7,11; ch1 at t=0,3,6; ch2 every cycle; clk_div ch0 high t=0..1 of each period, ch2 constant high.
REQ-037 lock glitch low for 1 cycle during FILTER at count 10 -> count restarts; ready delayed by 11 cycles.
REQ-038 pll_lock low in RUN -> ready low, outputs 0, lock_lost=1 three cycles later; lock_lost_clr same cycle as set -> lock_lost remains 1.
REQ-039 cfg_load in RUN with N0=0, P0=9 -> ch0 behaves as N=1 (clk_en every cycle) from cycle after load; N1=5, P1=9 -> P clamped to 4, clk_en at t=0,5.
REQ-040 ch_en[0] low for 5 cycles then high, N0=4 -> pulse positions identical to never-disabled run.
